// File: rtl/video_pkg.sv
// Shared types and constants for the video test-pattern transmitter.
package video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_ACT    = 2'd2,
    ST_HBLK   = 2'd3
  } state_t;

  localparam logic [1:0] PAT_XRAMP = 2'd0;
  localparam logic [1:0] PAT_YRAMP = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_SUM   = 2'd3;

  localparam int DEF_HACT = 1920;
  localparam int DEF_VACT = 1080;
  localparam int DEF_HBLK = 280;
  localparam int DEF_VBLK = 45;

  // Coordinate counter width shared by the top and the pixel generator
  localparam int CW = 16;

endpackage

// File: rtl/vpg_pattern.sv
// Combinational pixel generator: maps raster position, frame count and
// pattern code to a pixel value.
module vpg_pattern
  import video_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic [7:0]    frm,
  input  logic [1:0]    pat_sel,
  output logic [DW-1:0] dout
);

  always_comb begin
    dout = '0;
    case (pat_sel)
      PAT_XRAMP: dout = DW'(x);
      PAT_YRAMP: dout = DW'(y);
      PAT_CHECK: dout = (x[3] ^ y[3]) ? '1 : '0;
      PAT_SUM:   dout = DW'(x) + DW'(y) + DW'(frm);
      default:   dout = '0;
    endcase
  end

endmodule

// File: rtl/video_pattern_gen.sv
// Sensor-side video transmitter: frame/line timing FSM with registered
// vvalid/hvalid/dout stream and end-of-frame pulse.
module video_pattern_gen
  import video_pkg::*;
#(
  parameter int DW   = 8,
  parameter int HACT = DEF_HACT,
  parameter int VACT = DEF_VACT,
  parameter int HBLK = DEF_HBLK,
  parameter int VBLK = DEF_VBLK
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          en,
  input  logic [1:0]    pat_sel,
  output logic          vvalid,
  output logic          hvalid,
  output logic [DW-1:0] dout,
  output logic          frame_done,
  output logic          busy
);

  localparam int VB_CYC = VBLK * (HACT + HBLK);
  localparam int VBW    = $clog2(VB_CYC);

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_x, w_x_nxt;
  logic [CW-1:0]   r_y, w_y_nxt;
  logic [VBW-1:0]  r_vb, w_vb_nxt;
  logic [7:0]      r_frm, w_frm_nxt;
  logic [1:0]      r_pat, w_pat_nxt;

  logic            r_vvalid, r_hvalid, r_frame_done, r_busy;
  logic [DW-1:0]   r_dout;
  logic            w_vvalid_nxt, w_hvalid_nxt, w_frame_done_nxt, w_busy_nxt;
  logic [DW-1:0]   w_dout_nxt, w_pix;

  // Outputs are registered from next-state values so they line up with
  // the state they describe rather than lagging it by a cycle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state      <= ST_IDLE;
      r_x          <= '0;
      r_y          <= '0;
      r_vb         <= '0;
      r_frm        <= '0;
      r_pat        <= '0;
      r_vvalid     <= 1'b0;
      r_hvalid     <= 1'b0;
      r_dout       <= '0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_x          <= w_x_nxt;
      r_y          <= w_y_nxt;
      r_vb         <= w_vb_nxt;
      r_frm        <= w_frm_nxt;
      r_pat        <= w_pat_nxt;
      r_vvalid     <= w_vvalid_nxt;
      r_hvalid     <= w_hvalid_nxt;
      r_dout       <= w_dout_nxt;
      r_frame_done <= w_frame_done_nxt;
      r_busy       <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_vb_nxt    = r_vb;
    w_frm_nxt   = r_frm;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_nxt = ST_VBLANK;
          w_vb_nxt    = '0;
        end
      end
      ST_VBLANK: begin
        if (r_vb == VBW'(VB_CYC - 1)) begin
          w_state_nxt = ST_ACT;
          w_vb_nxt    = '0;
          w_x_nxt     = '0;
          w_y_nxt     = '0;
        end else begin
          w_vb_nxt = r_vb + VBW'(1);
        end
      end
      ST_ACT: begin
        if (r_x == CW'(HACT - 1)) begin
          w_state_nxt = ST_HBLK;
          w_x_nxt     = '0;
        end else begin
          w_x_nxt = r_x + CW'(1);
        end
      end
      ST_HBLK: begin
        if (r_x == CW'(HBLK - 1)) begin
          w_x_nxt = '0;
          if (r_y == CW'(VACT - 1)) begin
            // en is only honoured at the frame boundary
            w_state_nxt = en ? ST_VBLANK : ST_IDLE;
            w_y_nxt     = '0;
            w_vb_nxt    = '0;
            w_frm_nxt   = r_frm + 8'd1;
          end else begin
            w_state_nxt = ST_ACT;
            w_y_nxt     = r_y + CW'(1);
          end
        end else begin
          w_x_nxt = r_x + CW'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  vpg_pattern #(.DW(DW)) u_pattern (
    .x       (w_x_nxt),
    .y       (w_y_nxt),
    .frm     (r_frm),
    .pat_sel (r_pat),
    .dout    (w_pix)
  );

  always_comb begin
    w_hvalid_nxt     = (w_state_nxt == ST_ACT);
    w_vvalid_nxt     = (w_state_nxt == ST_ACT) || (w_state_nxt == ST_HBLK);
    w_busy_nxt       = (w_state_nxt != ST_IDLE);
    w_frame_done_nxt = (w_state_nxt == ST_HBLK) && (w_y_nxt == CW'(VACT - 1)) &&
                       (w_x_nxt == CW'(HBLK - 1));
    w_dout_nxt       = w_hvalid_nxt ? w_pix : '0;
    // Pattern is latched only when a frame's VBLANK begins
    w_pat_nxt        = ((w_state_nxt == ST_VBLANK) && (r_state != ST_VBLANK)) ?
                       pat_sel : r_pat;
  end

  assign vvalid     = r_vvalid;
  assign hvalid     = r_hvalid;
  assign dout       = r_dout;
  assign frame_done = r_frame_done;
  assign busy       = r_busy;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Randomized self-checking bench for video_pattern_gen against a
// frame-position reference model.
module tb_video_pattern_gen;

  localparam int DW   = 10;
  localparam int HACT = 4;
  localparam int VACT = 3;
  localparam int HBLK = 2;
  localparam int VBLK = 1;
  localparam int L    = HACT + HBLK;
  localparam int VB   = VBLK * L;
  localparam int P    = (VBLK + VACT) * L;

  logic          clk = 1'b0;
  logic          rst_b = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    pat_sel = 2'd0;
  logic          vvalid, hvalid, frame_done, busy;
  logic [DW-1:0] dout;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: whether a frame is running, position within the
  // frame period, frame counter and the pattern latched for this frame.
  bit m_run = 1'b0;
  int m_t   = 0;
  int m_frm = 0;
  int m_pat = 0;

  always #5 clk = ~clk;

  video_pattern_gen #(
    .DW(DW), .HACT(HACT), .VACT(VACT), .HBLK(HBLK), .VBLK(VBLK)
  ) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .en         (en),
    .pat_sel    (pat_sel),
    .vvalid     (vvalid),
    .hvalid     (hvalid),
    .dout       (dout),
    .frame_done (frame_done),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  function automatic int pix(input int x, input int y, input int f, input int p);
    int mask;
    mask = (1 << DW) - 1;
    case (p)
      0:       return x & mask;
      1:       return y & mask;
      2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? mask : 0;
      default: return (x + y + f) & mask;
    endcase
  endfunction

  task automatic model_step();
    if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        m_t   = 0;
        m_pat = int'(pat_sel);
      end
    end else if (m_t == P - 1) begin
      m_frm = (m_frm + 1) % 256;
      if (en) begin
        m_t   = 0;
        m_pat = int'(pat_sel);
      end else begin
        m_run = 1'b0;
      end
    end else begin
      m_t++;
    end
  endtask

  task automatic check_outputs();
    int e_vv, e_hv, e_fd, e_busy, e_dout, u, line, pos;
    e_vv = 0; e_hv = 0; e_fd = 0; e_busy = 0; e_dout = 0;
    if (m_run) begin
      e_busy = 1;
      if (m_t >= VB) begin
        u    = m_t - VB;
        line = u / L;
        pos  = u % L;
        e_vv = 1;
        e_hv = (pos < HACT) ? 1 : 0;
        e_fd = (line == VACT - 1 && pos == L - 1) ? 1 : 0;
        if (e_hv != 0) e_dout = pix(pos, line, m_frm, m_pat);
      end
    end
    chk("busy",       32'(busy),       32'(e_busy));
    chk("vvalid",     32'(vvalid),     32'(e_vv));
    chk("hvalid",     32'(hvalid),     32'(e_hv));
    chk("frame_done", 32'(frame_done), 32'(e_fd));
    chk("dout",       32'(dout),       32'(e_dout));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_b) model_step();
    @(negedge clk);
    check_outputs();
  endtask

  // Asserts reset asynchronously and checks outputs clear before any edge
  task automatic do_reset();
    rst_b = 1'b0;
    #1;
    m_run = 1'b0;
    m_t   = 0;
    m_frm = 0;
    check_outputs();
  endtask

  initial begin
    int vv_cnt, hv_cnt, fd_at, fd_cnt;

    repeat (2) @(negedge clk);
    check_outputs();

    // First frame with en high straight out of reset
    rst_b = 1'b1;
    en    = 1'b1;
    vv_cnt = 0; hv_cnt = 0; fd_at = 0;
    for (int k = 1; k <= P; k++) begin
      cycle();
      if (vvalid) vv_cnt++;
      if (hvalid) hv_cnt++;
      if (frame_done) fd_at = k;
    end
    chk("vvalid_cycles",   32'(vv_cnt), 32'd18);
    chk("hvalid_cycles",   32'(hv_cnt), 32'd12);
    chk("frame_done_cycle", 32'(fd_at), 32'd24);

    // Back-to-back frames: y ramp, then sum pattern
    pat_sel = 2'd1;
    repeat (P) cycle();
    pat_sel = 2'd3;
    repeat (P) cycle();

    // Ramp frame with a mid-frame switch to checker
    pat_sel = 2'd0;
    repeat (10) cycle();
    pat_sel = 2'd2;
    repeat (P - 10) cycle();

    // en dropped during line 1: frame still completes once
    fd_cnt = 0;
    repeat (VB + L + 1) cycle();
    en = 1'b0;
    for (int k = 0; k < 40; k++) begin
      cycle();
      if (frame_done) fd_cnt++;
    end
    chk("en_drop_fd_count", 32'(fd_cnt), 32'd1);
    chk("en_drop_idle",     32'(busy),   32'd0);

    // Reset during line 1 ACT aborts without frame_done
    en = 1'b1;
    repeat (VB + L + 2) cycle();
    chk("pre_reset_hvalid", 32'(hvalid), 32'd1);
    do_reset();
    fd_cnt = 0;
    for (int k = 0; k < 2; k++) begin
      cycle();
      if (frame_done) fd_cnt++;
    end
    chk("reset_no_fd", 32'(fd_cnt), 32'd0);
    rst_b = 1'b1;
    repeat (30) cycle();

    // Randomized inputs with occasional en drops and reset pulses
    for (int k = 0; k < 3000; k++) begin
      pat_sel = 2'($urandom_range(0, 3));
      en      = ($urandom_range(0, 99) < 90);
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        cycle();
        rst_b = 1'b1;
      end
      cycle();
    end

    // Long run of the sum pattern so the frame counter wraps
    en      = 1'b1;
    pat_sel = 2'd3;
    repeat (260 * P + 2) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
